// File: rtl/wb_arb2_rr.sv
// Two-master round-robin Wishbone arbiter sharing one slave port, with a bus watchdog.
// Latency: one cycle from cyc to grant; request mux and response routing are combinational.
// Backpressure: a tenure is held until the granted master drops cyc; stalled strobes end in err after TIMEOUT cycles.
module wb_arb2_rr #(
  parameter int AW      = 1,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  // master 0
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  // master 1
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  // shared slave port
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  // current grant, one-hot
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // Last watchdog count before a timeout fires; unused when TIMEOUT is 0.
  localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last;       // master that most recently finished a tenure
  logic        last_nxt;
  logic [15:0] wd;
  logic        tmo_err;
  logic        gnt0;
  logic        gnt1;
  logic        term;
  logic        grant_change;

  assign gnt0         = (state == G0);
  assign gnt1         = (state == G1);
  assign grant_o      = {gnt1, gnt0};
  assign term         = s_ack_i | s_err_i | s_rty_i;
  assign grant_change = (state_nxt != state);

  // State and round-robin pointer registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next grant: a tenure lasts while its cyc is high, then passes straight to a waiting peer.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? G0 : G1;
        else if (m0_cyc_i)        state_nxt = G0;
        else if (m1_cyc_i)        state_nxt = G1;
      end
      G0: begin
        if (!m0_cyc_i) begin
          last_nxt  = 1'b0;
          state_nxt = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          last_nxt  = 1'b1;
          state_nxt = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request mux: the granted master drives the slave; idle drives all zeros.
  // The strobe is masked during the timeout cycle so the slave sees the access end.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~tmo_err;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~tmo_err;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  // Response routing. Terminations are also gated by the master's own cyc so that a
  // late ack for an abandoned access never reaches anyone.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i             & gnt0 & m0_cyc_i;
  assign m0_rty_o = s_rty_i             & gnt0 & m0_cyc_i;
  assign m0_err_o = (s_err_i | tmo_err) & gnt0 & m0_cyc_i;
  assign m1_ack_o = s_ack_i             & gnt1 & m1_cyc_i;
  assign m1_rty_o = s_rty_i             & gnt1 & m1_cyc_i;
  assign m1_err_o = (s_err_i | tmo_err) & gnt1 & m1_cyc_i;

  // Watchdog: count unanswered strobe cycles, raise a one-cycle err at the limit.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd      <= 16'd0;
      tmo_err <= 1'b0;
    end else if (tmo_err) begin
      wd      <= 16'd0;
      tmo_err <= 1'b0;
    end else if (grant_change || !s_cyc_o || !s_stb_o || term) begin
      wd      <= 16'd0;
    end else if ((TIMEOUT != 0) && (wd == TMO_LAST)) begin
      wd      <= 16'd0;
      tmo_err <= 1'b1;
    end else begin
      wd      <= wd + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed bench for wb_arb2_rr: cycle table for arbitration and routing, hand sequences
// for the watchdog, asynchronous reset mid-burst and the disabled-watchdog long stall.
// A second instance with TIMEOUT=0 shares all inputs with the main TIMEOUT=8 instance.
module tb_wb_arb2_rr;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic [0:0] m0_adr = 1'b1, m1_adr = 1'b0;
  logic [7:0] m0_dat = 8'h3C, m1_dat = 8'hC3;
  logic       m0_we = 1'b1, m1_we = 1'b0;
  logic       m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
  logic [2:0] m0_cti = 3'b000, m1_cti = 3'b000;
  logic [1:0] m0_bte = 2'b00, m1_bte = 2'b01;
  logic [7:0] s_dat_i = 8'hA5;
  logic       s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  // main DUT outputs
  logic [7:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic       m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [0:0] s_adr_o;
  logic       s_we_o, s_cyc_o, s_stb_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o, grant_o;

  // TIMEOUT=0 DUT outputs
  logic [7:0] z_m0_dat_o, z_m1_dat_o, z_s_dat_o;
  logic       z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
  logic [0:0] z_s_adr_o;
  logic       z_s_we_o, z_s_cyc_o, z_s_stb_o;
  logic [2:0] z_s_cti_o;
  logic [1:0] z_s_bte_o, z_grant_o;

  int tests = 0;
  int fails = 0;

  always #5 wb_clk = ~wb_clk;

  wb_arb2_rr #(.AW(1), .DW(8), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(grant_o)
  );

  wb_arb2_rr #(.AW(1), .DW(8), .TIMEOUT(0)) dut_nowd (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_dat_o(z_m0_dat_o),
    .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_dat_o(z_m1_dat_o),
    .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
    .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_we_o(z_s_we_o), .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
    .s_cti_o(z_s_cti_o), .s_bte_o(z_s_bte_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(z_grant_o)
  );

  // One cycle of stimulus and the outputs expected during that cycle.
  // rsp = {m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty}
  typedef struct packed {
    logic       c0, s0, c1, s1;
    logic [2:0] cti1;
    logic       ack, err, rty;
    logic [1:0] gnt;
    logic       scyc, sstb;
    logic [7:0] sdat;
    logic [2:0] scti;
    logic [5:0] rsp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [30:0] v);
    vecs.push_back(vec_t'(v));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nerr;
    int nack;

    //    c0s0c1s1  cti1    a e r   gnt   cyc stb  sdat    scti    rsp
    add({4'b0000, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 3'b000, 6'b000000}); // 0 idle after reset
    add({4'b1111, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 3'b000, 6'b000000}); // 1 tie, grant not yet
    add({4'b1111, 3'b000, 3'b100, 2'b01, 2'b11, 8'h3C, 3'b000, 6'b100000}); // 2 m0 first, ack
    add({4'b0011, 3'b000, 3'b000, 2'b01, 2'b00, 8'h3C, 3'b000, 6'b000000}); // 3 m0 drops cyc
    add({4'b1111, 3'b000, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b000, 6'b010000}); // 4 m1 with no idle gap
    add({4'b1100, 3'b000, 3'b000, 2'b10, 2'b00, 8'hC3, 3'b000, 6'b000000}); // 5 m1 drops cyc
    add({4'b1111, 3'b000, 3'b100, 2'b01, 2'b11, 8'h3C, 3'b000, 6'b100000}); // 6 m0 again
    add({4'b0011, 3'b000, 3'b000, 2'b01, 2'b00, 8'h3C, 3'b000, 6'b000000}); // 7 m0 drops
    add({4'b0011, 3'b000, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b000, 6'b010000}); // 8 m1 again
    add({4'b0000, 3'b000, 3'b000, 2'b10, 2'b00, 8'hC3, 3'b000, 6'b000000}); // 9 all drop
    add({4'b0000, 3'b000, 3'b111, 2'b00, 2'b00, 8'h00, 3'b000, 6'b000000}); // 10 idle ignores slave
    add({4'b0011, 3'b010, 3'b000, 2'b00, 2'b00, 8'h00, 3'b000, 6'b000000}); // 11 m1 burst request
    add({4'b1111, 3'b010, 3'b001, 2'b10, 2'b11, 8'hC3, 3'b010, 6'b000001}); // 12 rty to m1 only
    add({4'b1111, 3'b010, 3'b010, 2'b10, 2'b11, 8'hC3, 3'b010, 6'b000100}); // 13 err to m1 only
    add({4'b1111, 3'b010, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b010, 6'b010000}); // 14 beat 1
    add({4'b1111, 3'b010, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b010, 6'b010000}); // 15 beat 2
    add({4'b1111, 3'b010, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b010, 6'b010000}); // 16 beat 3
    add({4'b1111, 3'b111, 3'b100, 2'b10, 2'b11, 8'hC3, 3'b111, 6'b010000}); // 17 beat 4, end of burst
    add({4'b1100, 3'b000, 3'b000, 2'b10, 2'b00, 8'hC3, 3'b000, 6'b000000}); // 18 m1 drops, m0 waits
    add({4'b1100, 3'b000, 3'b000, 2'b01, 2'b11, 8'h3C, 3'b000, 6'b000000}); // 19 m0 granted next cycle
    add({4'b0000, 3'b000, 3'b000, 2'b01, 2'b00, 8'h3C, 3'b000, 6'b000000}); // 20 m0 drops
    add({4'b0000, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 3'b000, 6'b000000}); // 21 back to idle

    // reset values while reset is held
    #3;
    check("reset_outputs",
          {11'd0, grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
           m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);
    repeat (2) @(posedge wb_clk);
    #1 wb_rst_n = 1'b1;

    // table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge wb_clk);
      #1;
      drive(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1);
      m1_cti = vecs[i].cti1;
      s_ack  = vecs[i].ack;
      s_err  = vecs[i].err;
      s_rty  = vecs[i].rty;
      @(negedge wb_clk);
      check($sformatf("vec%0d", i),
            {11'd0, grant_o, s_cyc_o, s_stb_o, s_dat_o, s_cti_o,
             m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o},
            {11'd0, vecs[i].gnt, vecs[i].scyc, vecs[i].sstb, vecs[i].sdat, vecs[i].scti, vecs[i].rsp});
    end

    // watchdog, TIMEOUT=8: m0 write never acked
    @(posedge wb_clk);
    #1;
    drive(1, 1, 0, 0);
    s_ack = 0; s_err = 0; s_rty = 0;
    @(posedge wb_clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge wb_clk);
      if (k == 0)
        check("wd_request_mux", {24'd0, s_adr_o, s_we_o, s_bte_o, 4'd0},
              {24'd0, 1'b1, 1'b1, 2'b00, 4'd0});
      check($sformatf("wd_err_cycle%0d", k), {31'd0, m0_err_o}, {31'd0, (k == 8)});
      if (k == 8) check("wd_stb_masked", {31'd0, s_stb_o}, 32'd0);
    end
    @(posedge wb_clk);
    #1 s_ack = 1;
    @(negedge wb_clk);
    check("wd_next_access", {24'd0, m0_dat_o, m1_dat_o[7:0] ^ 8'h00, 1'b0, s_stb_o, m0_ack_o, m0_err_o, 4'd0} >> 8,
          {16'd0, 8'hA5, 8'hA5, 4'b0110, 4'd0} >> 8);
    @(posedge wb_clk);
    #1;
    drive(0, 0, 0, 0);
    s_ack = 0;
    repeat (2) @(posedge wb_clk);

    // asynchronous reset in the middle of an m1 burst
    #1;
    drive(0, 0, 1, 1);
    m1_cti = 3'b010;
    repeat (2) @(posedge wb_clk);
    #1;
    check("rst_pre_grant", {30'd0, grant_o}, 32'd2);
    s_ack = 1;
    #1 wb_rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {28'd0, grant_o, s_cyc_o, m1_ack_o}, 32'd0);
    drive(1, 1, 1, 1);
    s_ack = 0;
    #1 wb_rst_n = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    check("rst_tie_m0_first", {30'd0, grant_o}, 32'd1);
    @(posedge wb_clk);
    #1;
    drive(0, 0, 0, 0);
    m1_cti = 3'b000;
    repeat (3) @(posedge wb_clk);

    // disabled watchdog: 1000-cycle stall then ack, on the TIMEOUT=0 instance
    #1;
    drive(1, 1, 0, 0);
    @(posedge wb_clk);
    nerr = 0;
    nack = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge wb_clk);
      if (z_m0_err_o) nerr++;
      if (z_m0_ack_o) nack++;
    end
    check("nowd_no_err", nerr, 0);
    check("nowd_no_early_ack", nack, 0);
    @(posedge wb_clk);
    #1 s_ack = 1;
    @(negedge wb_clk);
    check("nowd_ack_delivered", {29'd0, z_s_stb_o, z_m0_ack_o, z_m0_err_o}, 32'b110);
    @(posedge wb_clk);
    #1;
    s_ack = 0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge wb_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
